pll_seq_ctrl: RTL and testbench

Digital power-up sequencer and lock monitor for the user-area analog PLL. Drives the PLL's active-low VCO and charge-pump enables in a fixed order with programmable settle delays. Declares lock by counting a divided PLL feedback toggle against the Wishbone clock over fixed windows. Sits in the user project wrapper between the Wishbone configuration registers and the PLL macro.

---
 rtl/pll_pkg.sv | 24 ++
 rtl/pll_seq_ctrl_if.sv | 28 ++
 rtl/pll_edge_cnt.sv | 64 ++++++
 rtl/pll_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pll_pkg.sv
// Shared types and default constants for the PLL power-up sequencer and lock monitor.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_VCO_ON  = 3'd1,
        ST_CP_ON   = 3'd2,
        ST_MEASURE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } pll_state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int VCO_WAIT_DEF    = 1024;
    localparam int SETTLE_WAIT_DEF = 4096;
    localparam int WINDOW_DEF      = 1024;
    localparam int LOCK_GOOD_DEF   = 4;
    localparam int MAX_TRIES_DEF   = 64;

    function automatic logic is_busy(pll_state_e s);
        return (s == ST_VCO_ON) || (s == ST_CP_ON) || (s == ST_MEASURE);
    endfunction

endpackage

// File: rtl/pll_seq_ctrl_if.sv
// Control, configuration and status bundle between the wrapper registers and pll_seq_ctrl.
interface pll_seq_ctrl_if #(
    parameter int CNT_W = pll_pkg::CNT_W_DEF
);
    logic             start_i;
    logic             stop_i;
    logic             fb_toggle_i;
    logic [CNT_W-1:0] exp_cnt_i;
    logic [CNT_W-1:0] tol_i;
    logic             enb_vco_o;
    logic             enb_cp_o;
    logic             locked_o;
    logic             busy_o;
    logic             fault_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] last_cnt_o;
    logic [7:0]       relock_cnt_o;

    modport master (
        output start_i, stop_i, fb_toggle_i, exp_cnt_i, tol_i,
        input  enb_vco_o, enb_cp_o, locked_o, busy_o, fault_o, state_o, last_cnt_o, relock_cnt_o
    );

    modport slave (
        input  start_i, stop_i, fb_toggle_i, exp_cnt_i, tol_i,
        output enb_vco_o, enb_cp_o, locked_o, busy_o, fault_o, state_o, last_cnt_o, relock_cnt_o
    );
endinterface

// File: rtl/pll_edge_cnt.sv
// Synchronizes the PLL feedback toggle and counts its edges over fixed back-to-back windows.
module pll_edge_cnt #(
    parameter int CNT_W  = pll_pkg::CNT_W_DEF,
    parameter int WINDOW = pll_pkg::WINDOW_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             fb_toggle_i,
    input  logic             run_i,
    output logic             win_done_o,
    output logic [CNT_W-1:0] win_cnt_o,
    output logic [CNT_W-1:0] last_cnt_o
);
    localparam int TMR_W = $clog2(WINDOW + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW - 1);

    logic             sync1_q, sync2_q, hist_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_q, last_d, cnt_inc;
    logic             edge_w, done_w;

    always_comb begin
        edge_w  = sync2_q ^ hist_q;
        done_w  = run_i && (tmr_q == '0);
        cnt_inc = (edge_w && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (!run_i) begin
            tmr_d = TMR_LOAD;
            cnt_d = '0;
        end else if (done_w) begin
            // Edge seen on the closing cycle belongs to the closing window.
            tmr_d  = TMR_LOAD;
            cnt_d  = '0;
            last_d = cnt_inc;
        end else begin
            tmr_d = tmr_q - 1'b1;
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            tmr_q   <= TMR_LOAD;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            sync1_q <= fb_toggle_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign win_done_o = done_w;
    assign win_cnt_o  = cnt_inc;
    assign last_cnt_o = last_q;
endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL power-up sequencer and lock monitor. Define PLL_SEQ_AUTO_RELOCK_EN to make loss of
// lock re-enter MEASURE (counting relocks) instead of latching FAULT.
module pll_seq_ctrl
    import pll_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int VCO_WAIT    = VCO_WAIT_DEF,
    parameter int SETTLE_WAIT = SETTLE_WAIT_DEF,
    parameter int WINDOW      = WINDOW_DEF,
    parameter int LOCK_GOOD   = LOCK_GOOD_DEF,
    parameter int MAX_TRIES   = MAX_TRIES_DEF
) (
    input  logic           wb_clk_i,
    input  logic           wb_rstn_i,
    pll_seq_ctrl_if.slave  bus
);
    // state      | meaning
    // OFF        | both enables high, idle
    // VCO_ON     | VCO enabled, waiting VCO_WAIT
    // CP_ON      | charge pump enabled, waiting SETTLE_WAIT
    // MEASURE    | windows running, looking for LOCK_GOOD good in a row
    // LOCKED     | lock declared, windows still monitored
    // FAULT      | powered down, sticky fault, waits for start/stop

    localparam int DLY_MAX = (VCO_WAIT > SETTLE_WAIT) ? VCO_WAIT : SETTLE_WAIT;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int CTR_MAX = (LOCK_GOOD > MAX_TRIES) ? LOCK_GOOD : MAX_TRIES;
    localparam int CTR_W   = $clog2(CTR_MAX + 1);
    localparam logic [DLY_W-1:0] VCO_LOAD    = DLY_W'(VCO_WAIT - 1);
    localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE_WAIT - 1);
    localparam logic [CTR_W-1:0] GOOD_LAST   = CTR_W'(LOCK_GOOD - 1);
    localparam logic [CTR_W-1:0] TRY_LAST    = CTR_W'(MAX_TRIES - 1);

    pll_state_e       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [CTR_W-1:0] try_q, try_d, good_q, good_d;
    logic [7:0]       relock_q, relock_d;
    logic             fault_q, fault_d;
    logic             enb_vco_q, enb_vco_d, enb_cp_q, enb_cp_d, locked_q, locked_d, busy_q, busy_d;
    logic             run, win_done, win_good;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W:0]   dev;

    assign run = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);

    pll_edge_cnt #(.CNT_W(CNT_W), .WINDOW(WINDOW)) u_edge_cnt (
        .wb_clk_i    (wb_clk_i),
        .wb_rstn_i   (wb_rstn_i),
        .fb_toggle_i (bus.fb_toggle_i),
        .run_i       (run),
        .win_done_o  (win_done),
        .win_cnt_o   (win_cnt),
        .last_cnt_o  (bus.last_cnt_o)
    );

    always_comb begin
        if (win_cnt >= bus.exp_cnt_i) dev = {1'b0, win_cnt} - {1'b0, bus.exp_cnt_i};
        else                          dev = {1'b0, bus.exp_cnt_i} - {1'b0, win_cnt};
        win_good = (dev <= {1'b0, bus.tol_i});
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        try_d    = try_q;
        good_d   = good_q;
        fault_d  = fault_q;
        relock_d = relock_q;
        case (state_q)
            ST_OFF: if (bus.start_i) begin
                state_d = ST_VCO_ON;
                dly_d   = VCO_LOAD;
                fault_d = 1'b0;
            end
            ST_VCO_ON: if (dly_q == '0) begin
                state_d = ST_CP_ON;
                dly_d   = SETTLE_LOAD;
            end else dly_d = dly_q - 1'b1;
            ST_CP_ON: if (dly_q == '0) begin
                state_d = ST_MEASURE;
                try_d   = '0;
                good_d  = '0;
            end else dly_d = dly_q - 1'b1;
            ST_MEASURE: if (win_done) begin
                try_d  = try_q + 1'b1;
                good_d = win_good ? good_q + 1'b1 : '0;
                if (win_good && (good_q == GOOD_LAST)) state_d = ST_LOCKED;
                else if (try_q == TRY_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
            end
            ST_LOCKED: if (win_done && !win_good) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                state_d = ST_MEASURE;
                try_d   = '0;
                good_d  = '0;
                if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
`else
                state_d = ST_FAULT;
                fault_d = 1'b1;
`endif
            end
            ST_FAULT: if (bus.start_i) begin
                state_d = ST_VCO_ON;
                dly_d   = VCO_LOAD;
            end
            default: state_d = ST_OFF;
        endcase
        // stop wins over everything, including a fault raised this same cycle
        if (bus.stop_i) begin
            state_d = ST_OFF;
            fault_d = fault_q;
        end
        enb_vco_d = !((state_d == ST_VCO_ON) || (state_d == ST_CP_ON) ||
                      (state_d == ST_MEASURE) || (state_d == ST_LOCKED));
        enb_cp_d  = !((state_d == ST_CP_ON) || (state_d == ST_MEASURE) || (state_d == ST_LOCKED));
        locked_d  = (state_d == ST_LOCKED);
        busy_d    = is_busy(state_d);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q   <= ST_OFF;
            dly_q     <= '0;
            try_q     <= '0;
            good_q    <= '0;
            fault_q   <= 1'b0;
            relock_q  <= '0;
            enb_vco_q <= 1'b1;
            enb_cp_q  <= 1'b1;
            locked_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            try_q     <= try_d;
            good_q    <= good_d;
            fault_q   <= fault_d;
            relock_q  <= relock_d;
            enb_vco_q <= enb_vco_d;
            enb_cp_q  <= enb_cp_d;
            locked_q  <= locked_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.state_o      = state_q;
    assign bus.enb_vco_o    = enb_vco_q;
    assign bus.enb_cp_o     = enb_cp_q;
    assign bus.locked_o     = locked_q;
    assign bus.busy_o       = busy_q;
    assign bus.fault_o      = fault_q;
    assign bus.relock_cnt_o = relock_q;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl with shortened delays; a second CNT_W=4 instance checks saturation.
module tb_pll_seq_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tog_mode = 0;
    logic tog_phase = 1'b0;

    always #5 clk = ~clk;

    pll_seq_ctrl_if #(.CNT_W(16)) bus ();
    pll_seq_ctrl_if #(.CNT_W(4))  bus4 ();

    pll_seq_ctrl #(.CNT_W(16), .VCO_WAIT(8), .SETTLE_WAIT(16), .WINDOW(32),
                   .LOCK_GOOD(2), .MAX_TRIES(4)) u_dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus.slave)
    );

    pll_seq_ctrl #(.CNT_W(4), .VCO_WAIT(8), .SETTLE_WAIT(16), .WINDOW(32),
                   .LOCK_GOOD(2), .MAX_TRIES(4)) u_dut4 (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus4.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 1: toggle every 2 cycles (16 edges per 32-cycle window); bus4 toggles every cycle
    initial begin
        bus.fb_toggle_i  = 1'b0;
        bus4.fb_toggle_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode == 1) begin
                if (tog_phase) bus.fb_toggle_i = ~bus.fb_toggle_i;
                tog_phase = ~tog_phase;
            end
            if (rstn) bus4.fb_toggle_i = ~bus4.fb_toggle_i;
        end
    end

    initial begin
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.exp_cnt_i  = 16'd16;
        bus.tol_i      = 16'd1;
        bus4.start_i   = 1'b0;
        bus4.stop_i    = 1'b0;
        bus4.exp_cnt_i = 4'd15;
        bus4.tol_i     = 4'd0;

        tick(3);
        chk("rst_state",   32'(bus.state_o), 0);
        chk("rst_enb_vco", 32'(bus.enb_vco_o), 1);
        chk("rst_enb_cp",  32'(bus.enb_cp_o), 1);
        rstn = 1'b1;
        tick(2);
        chk("idle_state",  32'(bus.state_o), 0);
        chk("idle_locked", 32'(bus.locked_o), 0);
        chk("idle_busy",   32'(bus.busy_o), 0);
        chk("idle_fault",  32'(bus.fault_o), 0);
        chk("idle_last",   32'(bus.last_cnt_o), 0);
        chk("idle_relock", 32'(bus.relock_cnt_o), 0);

        // lock run
        tog_mode = 1;
        tick(4);
        bus.start_i = 1'b1; bus4.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0; bus4.start_i = 1'b0;
        chk("vco_fall",    32'(bus.enb_vco_o), 0);
        chk("vco_state",   32'(bus.state_o), 1);
        chk("vco_busy",    32'(bus.busy_o), 1);
        chk("vco_cp_high", 32'(bus.enb_cp_o), 1);
        tick(7);
        chk("cp_plus8",    32'(bus.enb_cp_o), 1);
        tick(1);
        chk("cp_plus9",    32'(bus.enb_cp_o), 0);
        chk("cp_state",    32'(bus.state_o), 2);
        tick(15);
        chk("settle_end",  32'(bus.state_o), 2);
        tick(1);
        chk("meas_enter",  32'(bus.state_o), 3);
        tick(32);
        chk("win1_state",  32'(bus.state_o), 3);
        chk("win1_last",   32'(bus.last_cnt_o), 16);
        chk("win1_locked", 32'(bus.locked_o), 0);
        chk("sat_win1",    32'(bus4.last_cnt_o), 15);
        tick(32);
        chk("win2_state",  32'(bus.state_o), 4);
        chk("win2_locked", 32'(bus.locked_o), 1);
        chk("win2_last",   32'(bus.last_cnt_o), 16);
        chk("win2_busy",   32'(bus.busy_o), 0);
        chk("sat_win2",    32'(bus4.last_cnt_o), 15);
        chk("sat_locked",  32'(bus4.locked_o), 1);

        // loss of lock
        tog_mode = 0;
        tick(31);
        chk("lol_hold",    32'(bus.state_o), 4);
        tick(1);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        chk("lol_state",   32'(bus.state_o), 3);
        chk("lol_relock",  32'(bus.relock_cnt_o), 1);
        chk("lol_locked",  32'(bus.locked_o), 0);
        chk("lol_enb_vco", 32'(bus.enb_vco_o), 0);
`else
        chk("lol_state",   32'(bus.state_o), 5);
        chk("lol_fault",   32'(bus.fault_o), 1);
        chk("lol_enb_vco", 32'(bus.enb_vco_o), 1);
        chk("lol_enb_cp",  32'(bus.enb_cp_o), 1);
        chk("lol_relock",  32'(bus.relock_cnt_o), 0);
`endif
        bus.stop_i = 1'b1;
        tick(1);
        bus.stop_i = 1'b0;
        chk("stop_state",  32'(bus.state_o), 0);
        chk("stop_enb_vco", 32'(bus.enb_vco_o), 1);
        chk("stop_enb_cp", 32'(bus.enb_cp_o), 1);
        chk("stop_locked", 32'(bus.locked_o), 0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        chk("stop_fault",  32'(bus.fault_o), 0);
`else
        chk("stop_fault",  32'(bus.fault_o), 1);
`endif

        // lock never achieved
        bus.exp_cnt_i = 16'd10;
        tog_mode = 1;
        tick(2);
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        chk("f_start_state", 32'(bus.state_o), 1);
        chk("f_start_fault", 32'(bus.fault_o), 0);
        tick(3);
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        chk("f_ign_start", 32'(bus.state_o), 1);
        tick(3);
        chk("f_cp_plus8",  32'(bus.enb_cp_o), 1);
        tick(1);
        chk("f_cp_plus9",  32'(bus.enb_cp_o), 0);
        tick(16);
        chk("f_meas",      32'(bus.state_o), 3);
        tick(127);
        chk("f_win4_pre",  32'(bus.state_o), 3);
        tick(1);
        chk("f_state",     32'(bus.state_o), 5);
        chk("f_fault",     32'(bus.fault_o), 1);
        chk("f_enb_vco",   32'(bus.enb_vco_o), 1);
        chk("f_enb_cp",    32'(bus.enb_cp_o), 1);
        chk("f_busy",      32'(bus.busy_o), 0);
        chk("f_last",      32'(bus.last_cnt_o), 16);

        // stop and start together during CP_ON
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        tick(9);
        chk("ss_cp_on",    32'(bus.state_o), 2);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        chk("ss_state",    32'(bus.state_o), 0);
        chk("ss_enb_vco",  32'(bus.enb_vco_o), 1);
        chk("ss_enb_cp",   32'(bus.enb_cp_o), 1);
        chk("ss_fault",    32'(bus.fault_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
